// File: rtl/bpu_pht_gshare_if.sv
// Lookup, resolve-stage update and statistics signals of the gshare/bimodal branch predictor.
// The pipeline drives through the master modport and the predictor sits on the slave side.
interface bpu_pht_gshare_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned GHR_W  = 8,
  parameter int unsigned STAT_W = 32
) ();

  logic              lookup_en;
  logic              lookup_br;
  logic [PC_W-1:0]   lookup_pc;
  logic              stall;
  logic              pred_take;
  logic [GHR_W-1:0]  pred_ghr;

  logic              upd_en;
  logic [PC_W-1:0]   upd_pc;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_actual;
  logic              upd_pred;
  logic              mispredict;

  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_misses;

  modport master (
    output lookup_en, lookup_br, lookup_pc, stall,
    output upd_en, upd_pc, upd_ghr, upd_actual, upd_pred,
    input  pred_take, pred_ghr, mispredict, stat_lookups, stat_misses
  );

  modport slave (
    input  lookup_en, lookup_br, lookup_pc, stall,
    input  upd_en, upd_pc, upd_ghr, upd_actual, upd_pred,
    output pred_take, pred_ghr, mispredict, stat_lookups, stat_misses
  );

endinterface

// File: rtl/bpu_pht_gshare.sv
// Pattern history table branch predictor (bimodal or gshare) with a speculative global
// history register, mispredict-driven history recovery and saturating statistics counters.
module bpu_pht_gshare #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned GHR_W  = 8,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned MODE   = 1,
  parameter int unsigned STAT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  bpu_pht_gshare_if.slave     bus
);

  localparam int unsigned      Entries = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CntInit = CNT_W'((2 ** (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [STAT_W-1:0] StatOne = STAT_W'(1);

  logic [CNT_W-1:0]  pht_q [Entries];
  logic [GHR_W-1:0]  spec_ghr_q, spec_ghr_d;
  logic [STAT_W-1:0] lookups_q, lookups_d;
  logic [STAT_W-1:0] misses_q, misses_d;

  logic [IDX_W-1:0]  lookup_base, upd_base;
  logic [IDX_W-1:0]  lookup_idx, upd_idx;
  logic [CNT_W-1:0]  upd_cnt, upd_cnt_d;
  logic              pred_take;
  logic              mispredict;
  logic              lookup_fire;

  // PC bits outside the index field never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.lookup_pc[PC_W-1:IDX_W+2],
                            bus.upd_pc[1:0], bus.upd_pc[PC_W-1:IDX_W+2]};

  assign lookup_base = bus.lookup_pc[IDX_W+1:2];
  assign upd_base    = bus.upd_pc[IDX_W+1:2];
  assign lookup_idx  = (MODE == 0) ? lookup_base : (lookup_base ^ IDX_W'(spec_ghr_q));
  assign upd_idx     = (MODE == 0) ? upd_base : (upd_base ^ IDX_W'(bus.upd_ghr));

  assign pred_take   = pht_q[lookup_idx][CNT_W-1];
  assign mispredict  = bus.upd_en & (bus.upd_actual != bus.upd_pred);
  assign lookup_fire = bus.lookup_en & bus.lookup_br & ~bus.stall;

  assign bus.pred_take    = pred_take;
  assign bus.pred_ghr     = spec_ghr_q;
  assign bus.mispredict   = mispredict;
  assign bus.stat_lookups = lookups_q;
  assign bus.stat_misses  = misses_q;

  // Saturating counter training.
  always_comb begin
    upd_cnt   = pht_q[upd_idx];
    upd_cnt_d = upd_cnt;
    if (bus.upd_actual) begin
      if (upd_cnt != CntMax) upd_cnt_d = upd_cnt + CntOne;
    end else begin
      if (upd_cnt != '0) upd_cnt_d = upd_cnt - CntOne;
    end
  end

  // Recovery beats the D-stage shift: that lookup is on the wrong path.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (mispredict) begin
      spec_ghr_d = GHR_W'({bus.upd_ghr, bus.upd_actual});
    end else if (lookup_fire) begin
      spec_ghr_d = GHR_W'({spec_ghr_q, pred_take});
    end
  end

  always_comb begin
    lookups_d = lookups_q;
    misses_d  = misses_q;
    if (lookup_fire && !mispredict && (lookups_q != '1)) lookups_d = lookups_q + StatOne;
    if (mispredict && (misses_q != '1)) misses_d = misses_q + StatOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Entries; i++) pht_q[i] <= CntInit;
    end else if (bus.upd_en) begin
      pht_q[upd_idx] <= upd_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_ghr_q <= '0;
      lookups_q  <= '0;
      misses_q   <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      lookups_q  <= lookups_d;
      misses_q   <= misses_d;
    end
  end

endmodule

// File: tb/tb_bpu_pht_gshare.sv
// Directed bench for bpu_pht_gshare: one bimodal and one gshare instance, expectations
// queued by the stimulus and compared by an independent monitor.
module tb_bpu_pht_gshare;

  localparam int FPredTake = 0;
  localparam int FPredGhr  = 1;
  localparam int FMisp     = 2;
  localparam int FLookups  = 3;
  localparam int FMisses   = 4;

  typedef struct {
    int          dut;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst_ni;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  event chk_ev;

  bpu_pht_gshare_if #(.PC_W(32), .GHR_W(8), .STAT_W(32)) b0 ();
  bpu_pht_gshare_if #(.PC_W(32), .GHR_W(8), .STAT_W(32)) b1 ();

  bpu_pht_gshare #(.PC_W(32), .IDX_W(10), .GHR_W(8), .CNT_W(2), .MODE(0), .STAT_W(32)) u_bim (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (b0.slave)
  );

  bpu_pht_gshare #(.PC_W(32), .IDX_W(10), .GHR_W(8), .CNT_W(2), .MODE(1), .STAT_W(32)) u_gsh (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get(int d, int f);
    logic [31:0] v;
    v = '0;
    if (d == 0) begin
      case (f)
        FPredTake: v = {31'd0, b0.pred_take};
        FPredGhr:  v = {24'd0, b0.pred_ghr};
        FMisp:     v = {31'd0, b0.mispredict};
        FLookups:  v = b0.stat_lookups;
        default:   v = b0.stat_misses;
      endcase
    end else begin
      case (f)
        FPredTake: v = {31'd0, b1.pred_take};
        FPredGhr:  v = {24'd0, b1.pred_ghr};
        FMisp:     v = {31'd0, b1.mispredict};
        FLookups:  v = b1.stat_lookups;
        default:   v = b1.stat_misses;
      endcase
    end
    return v;
  endfunction

  function automatic void expect_v(int d, int f, logic [31:0] v, string nm);
    exp_t e;
    e.dut = d; e.fld = f; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endfunction

  // Monitor: drains the scoreboard at every falling edge or on an explicit sample request.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = get(e.dut, e.fld);
        n_checks++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", e.name, e.dut, act, e.val);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    b0.lookup_en = 0; b0.lookup_br = 0; b0.stall = 0;
    b0.upd_en = 0; b0.upd_pc = '0; b0.upd_ghr = '0; b0.upd_actual = 0; b0.upd_pred = 0;
  endtask

  task automatic idle1();
    b1.lookup_en = 0; b1.lookup_br = 0; b1.stall = 0;
    b1.upd_en = 0; b1.upd_pc = '0; b1.upd_ghr = '0; b1.upd_actual = 0; b1.upd_pred = 0;
  endtask

  task automatic upd0(logic act, logic prd);
    b0.upd_en = 1; b0.upd_pc = 32'h0040_0010; b0.upd_ghr = '0;
    b0.upd_actual = act; b0.upd_pred = prd;
  endtask

  task automatic upd1(logic [31:0] pc, logic [7:0] ghr, logic act, logic prd);
    b1.upd_en = 1; b1.upd_pc = pc; b1.upd_ghr = ghr; b1.upd_actual = act; b1.upd_pred = prd;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 0;
    idle0(); idle1();
    b0.lookup_pc = 32'h0040_0010;
    b1.lookup_pc = 32'h0040_0010;
    #12 rst_ni = 1;

    // Post-reset lookup on both instances.
    nxt();
    b0.lookup_en = 1; b0.lookup_br = 1;
    b1.lookup_en = 1; b1.lookup_br = 1;
    for (int d = 0; d < 2; d++) begin
      expect_v(d, FPredTake, 0, "reset_pred_take");
      expect_v(d, FPredGhr, 8'h00, "reset_pred_ghr");
      expect_v(d, FMisp, 0, "reset_mispredict");
      expect_v(d, FLookups, 0, "reset_stat_lookups");
    end
    nxt();
    idle0(); idle1();
    for (int d = 0; d < 2; d++) begin
      expect_v(d, FPredGhr, 8'h00, "ghr_after_lookup");
      expect_v(d, FLookups, 1, "lookups_after_lookup");
    end

    // Bimodal training: 01 -> 10 -> 11 -> 11, then two not-taken -> 01.
    nxt(); upd0(1, 0); expect_v(0, FPredTake, 0, "bim_u1_pred"); expect_v(0, FMisp, 1, "bim_u1_misp");
    nxt(); upd0(1, 1); expect_v(0, FPredTake, 1, "bim_u2_pred"); expect_v(0, FMisp, 0, "bim_u2_misp");
    nxt(); upd0(1, 1); expect_v(0, FPredTake, 1, "bim_u3_pred"); expect_v(0, FMisp, 0, "bim_u3_misp");
    nxt(); upd0(0, 1); expect_v(0, FPredTake, 1, "bim_sat_pred"); expect_v(0, FMisp, 1, "bim_u4_misp");
    nxt(); upd0(0, 1); expect_v(0, FPredTake, 1, "bim_u5_pred");
    nxt(); idle0();
    expect_v(0, FPredTake, 0, "bim_back_to_weak_nt");
    expect_v(0, FMisses, 3, "bim_stat_misses");
    expect_v(0, FLookups, 1, "bim_stat_lookups");

    // Gshare: steer spec_ghr to 0x03 by recovery, then train PHT[0x007].
    nxt(); upd1(32'h0040_0100, 8'h01, 1, 0);
    expect_v(1, FMisp, 1, "gsh_recover_misp");
    nxt(); upd1(32'h0040_0010, 8'h03, 1, 1);
    expect_v(1, FPredGhr, 8'h03, "gsh_ghr_03");
    expect_v(1, FPredTake, 0, "gsh_idx7_weak");
    expect_v(1, FMisp, 0, "gsh_train_no_misp");
    nxt(); upd1(32'h0040_0010, 8'h03, 1, 1);
    expect_v(1, FPredTake, 1, "gsh_idx7_after_one");
    nxt(); idle1();
    expect_v(1, FPredTake, 1, "gsh_idx7_strong");
    expect_v(1, FMisses, 1, "gsh_misses_1");
    nxt(); upd1(32'h0040_0200, 8'h00, 0, 1);
    expect_v(1, FMisp, 1, "gsh_recover_to_0");
    nxt(); idle1();
    expect_v(1, FPredGhr, 8'h00, "gsh_ghr_00");
    expect_v(1, FPredTake, 0, "gsh_idx4_untouched");
    expect_v(1, FMisses, 2, "gsh_misses_2");

    // Recovery wins over a concurrent taken lookup.
    nxt();
    b1.lookup_en = 1; b1.lookup_br = 1; b1.lookup_pc = 32'h0040_001C;
    upd1(32'h0040_0300, 8'h5A, 1, 0);
    expect_v(1, FPredTake, 1, "rec_lookup_taken");
    expect_v(1, FMisp, 1, "rec_mispredict");
    expect_v(1, FPredGhr, 8'h00, "rec_ghr_before");

    // Stall for four cycles; the last one also carries a mispredict.
    for (int i = 0; i < 4; i++) begin
      nxt(); idle1();
      b1.lookup_en = 1; b1.lookup_br = 1; b1.stall = 1;
      if (i == 3) upd1(32'h0040_0400, 8'h0F, 0, 1);
      expect_v(1, FPredGhr, 8'hB5, "stall_ghr_held");
      expect_v(1, FLookups, 1, "stall_lookups_held");
      if (i == 0) expect_v(1, FMisses, 3, "rec_misses_3");
    end
    nxt(); idle1();
    b1.lookup_en = 1; b1.lookup_br = 1; b1.lookup_pc = 32'h0040_0064;
    expect_v(1, FPredGhr, 8'h1E, "stall_recovered_ghr");
    expect_v(1, FPredTake, 1, "gsh_idx7_via_ghr1e");
    expect_v(1, FMisses, 4, "stall_misses_4");
    nxt(); idle1();
    upd0(1, 0);
    expect_v(1, FPredGhr, 8'h3D, "shift_in_taken");
    expect_v(1, FLookups, 2, "lookups_2");

    // Asynchronous reset between clock edges.
    nxt(); idle0(); idle1();
    expect_v(0, FPredTake, 1, "bim_pre_reset_taken");
    expect_v(0, FMisses, 4, "bim_pre_reset_misses");
    @(negedge clk);
    #1 rst_ni = 0;
    #1;
    expect_v(0, FPredTake, 0, "areset_bim_pred");
    expect_v(0, FMisses, 0, "areset_bim_misses");
    expect_v(0, FLookups, 0, "areset_bim_lookups");
    expect_v(1, FPredGhr, 8'h00, "areset_gsh_ghr");
    expect_v(1, FLookups, 0, "areset_gsh_lookups");
    expect_v(1, FMisses, 0, "areset_gsh_misses");
    -> chk_ev;
    #1 rst_ni = 1;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
